fetch_decode_queue: RTL

Instruction queue between the fetch stage and the decode stage. Each cycle it accepts a {pc, instruction} pair from fetch and holds it in a small circular FIFO. It presents the oldest entry to decode under a valid/ready handshake. It back-pressures the next-PC logic when full, and discards all queued entries on a control-flow redirect (flush).

---
 rtl/fetch_decode_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, instr} pairs
// with valid/ready handshake, full back-pressure and flush-on-redirect.
module fetch_decode_queue #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready,
  input  logic          flush,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;

  // Handshake qualifiers derived from registered occupancy only
  always_comb begin
    full_s  = (count_r == CW'(DEPTH));
    empty_s = (count_r == {CW{1'b0}});
    push_s  = in_valid & ~full_s;
    pop_s   = out_ready & ~empty_s;
  end

  // Occupancy next-state; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; flush outranks any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= {in_pc, in_instr};
    end
  end

  // Head presentation; zeroed when empty so decode never sees stale data
  always_comb begin
    in_ready  = ~full_s;
    out_valid = ~empty_s;
    count     = count_r;
    if (!empty_s) begin
      out_pc    = mem_r[rd_ptr_r][63:32];
      out_instr = mem_r[rd_ptr_r][31:0];
    end else begin
      out_pc    = 32'h0;
      out_instr = 32'h0;
    end
  end

endmodule
